itch_rx_frame_arbiter: RTL and testbench

- Two-port, frame-granular arbiter in front of the ITCH packet receiver.
- Merges two 64-bit Ethernet beat streams (feed A = port 0, feed B = port 1) into one registered stream for the receiver.
- Grants round-robin per frame, holding the grant from SOF to EOF.
- Discards stray beats, truncates oversize frames, and keeps per-port frame counters and error counters.

---
 rtl/itch_rx_frame_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_itch_rx_frame_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_rx_frame_arbiter.sv
// itch_rx_frame_arbiter
// Merges two 64-bit beat streams (feed A = port 0, feed B = port 1) into one
// registered stream for the ITCH receiver. Grants round-robin per frame and
// holds the grant from SOF to EOF. Drops stray beats seen while idle and
// truncates frames longer than MAX_BEATS. Keeps per-port frame counters and
// saturating error counters.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_data/sof/eof/len/vld_<n>   input beat streams, port n = 0/1
//   in_rdy_<n>                    beat accepted when vld && rdy (combinational)
//   out_data/sof/eof/len          registered output beat
//   out_vld, out_rdy              output handshake
//   out_trunc                     set on a forced-EOF beat
//   out_port                      source port of the output beat
//   frm_cnt_<n>                   completed frames per port, wrapping
//   stray_cnt, trunc_cnt,
//   sof_err_cnt                   saturating error counters
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for SOF; arbitrates; non-SOF beats are accepted and dropped
// FWD   | forwarding the granted port's frame into the output register
// DRAIN | frame was truncated; discard the granted port's beats until EOF
module itch_rx_frame_arbiter #(
    parameter int MAX_BEATS = 192,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in_data_0,
    input  logic             in_sof_0,
    input  logic             in_eof_0,
    input  logic [2:0]       in_len_0,
    input  logic             in_vld_0,
    output logic             in_rdy_0,
    input  logic [63:0]      in_data_1,
    input  logic             in_sof_1,
    input  logic             in_eof_1,
    input  logic [2:0]       in_len_1,
    input  logic             in_vld_1,
    output logic             in_rdy_1,
    output logic [63:0]      out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic [2:0]       out_len,
    output logic             out_vld,
    output logic             out_trunc,
    output logic             out_port,
    input  logic             out_rdy,
    output logic [31:0]      frm_cnt_0,
    output logic [31:0]      frm_cnt_1,
    output logic [ERR_W-1:0] stray_cnt,
    output logic [ERR_W-1:0] trunc_cnt,
    output logic [ERR_W-1:0] sof_err_cnt
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_DRAIN} state_t;

    state_t        state, state_nx;
    logic          grant, grant_nx;
    logic          last_grant, last_grant_nx;
    logic [BW-1:0] beat_cnt, beat_cnt_nx;

    logic          can_load;
    logic          sel_vld, sel_sof, sel_eof;
    logic [63:0]   sel_data;
    logic [2:0]    sel_len;
    logic          at_max;
    logic          cand_0, cand_1;

    logic          load;
    logic          fwd_sof, fwd_eof, fwd_trunc;
    logic [2:0]    fwd_len;
    logic [1:0]    stray_inc;
    logic          sof_err_hit, trunc_hit, frm_done;

    assign can_load = !out_vld || out_rdy;
    assign sel_vld  = grant ? in_vld_1  : in_vld_0;
    assign sel_sof  = grant ? in_sof_1  : in_sof_0;
    assign sel_eof  = grant ? in_eof_1  : in_eof_0;
    assign sel_data = grant ? in_data_1 : in_data_0;
    assign sel_len  = grant ? in_len_1  : in_len_0;
    assign at_max   = (beat_cnt == BW'(MAX_BEATS - 1));
    assign cand_0   = in_vld_0 && in_sof_0;
    assign cand_1   = in_vld_1 && in_sof_1;

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] c,
                                                  input logic [1:0] inc);
        logic [ERR_W:0] s;
        s = {1'b0, c} + (ERR_W + 1)'(inc);
        return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        beat_cnt_nx   = beat_cnt;
        in_rdy_0      = 1'b0;
        in_rdy_1      = 1'b0;
        load          = 1'b0;
        fwd_sof       = 1'b0;
        fwd_eof       = sel_eof;
        fwd_len       = sel_len;
        fwd_trunc     = 1'b0;
        stray_inc     = 2'd0;
        sof_err_hit   = 1'b0;
        trunc_hit     = 1'b0;
        frm_done      = 1'b0;
        case (state)
            S_IDLE: begin
                // SOF beats wait out one arbitration cycle; anything else is stray.
                in_rdy_0  = in_vld_0 && !in_sof_0;
                in_rdy_1  = in_vld_1 && !in_sof_1;
                stray_inc = {1'b0, in_vld_0 && !in_sof_0} + {1'b0, in_vld_1 && !in_sof_1};
                if (cand_0 || cand_1) begin
                    grant_nx      = (cand_0 && cand_1) ? !last_grant : cand_1;
                    last_grant_nx = grant_nx;
                    beat_cnt_nx   = '0;
                    state_nx      = S_FWD;
                end
            end
            S_FWD: begin
                if (grant) in_rdy_1 = can_load;
                else       in_rdy_0 = can_load;
                if (sel_vld && can_load) begin
                    load        = 1'b1;
                    fwd_sof     = sel_sof && (beat_cnt == '0);
                    sof_err_hit = sel_sof && (beat_cnt != '0);
                    if (sel_eof) begin
                        frm_done    = 1'b1;
                        beat_cnt_nx = '0;
                        state_nx    = S_IDLE;
                    end else if (at_max) begin
                        fwd_eof   = 1'b1;
                        fwd_len   = 3'd0;
                        fwd_trunc = 1'b1;
                        trunc_hit = 1'b1;
                        state_nx  = S_DRAIN;
                    end else begin
                        beat_cnt_nx = beat_cnt + BW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (grant) in_rdy_1 = 1'b1;
                else       in_rdy_0 = 1'b1;
                if (sel_vld && sel_eof) begin
                    beat_cnt_nx = '0;
                    state_nx    = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_len     <= '0;
            out_vld     <= 1'b0;
            out_trunc   <= 1'b0;
            out_port    <= 1'b0;
            frm_cnt_0   <= '0;
            frm_cnt_1   <= '0;
            stray_cnt   <= '0;
            trunc_cnt   <= '0;
            sof_err_cnt <= '0;
        end else begin
            if (load) begin
                out_data  <= sel_data;
                out_sof   <= fwd_sof;
                out_eof   <= fwd_eof;
                out_len   <= fwd_len;
                out_trunc <= fwd_trunc;
                out_port  <= grant;
                out_vld   <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
            if (frm_done && !grant) frm_cnt_0 <= frm_cnt_0 + 32'd1;
            if (frm_done &&  grant) frm_cnt_1 <= frm_cnt_1 + 32'd1;
            stray_cnt   <= sat_add(stray_cnt, stray_inc);
            trunc_cnt   <= sat_add(trunc_cnt, {1'b0, trunc_hit});
            sof_err_cnt <= sat_add(sof_err_cnt, {1'b0, sof_err_hit});
        end
    end

endmodule

// File: tb/tb_itch_rx_frame_arbiter.sv
// Directed bench for itch_rx_frame_arbiter, built with MAX_BEATS=4 and
// ERR_W=2 so truncation and counter saturation are reachable quickly.
module tb_itch_rx_frame_arbiter;

    localparam int MAXB = 4;
    localparam int EW   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] d   [2];
    logic        sof [2];
    logic        eof [2];
    logic [2:0]  len [2];
    logic        vld [2];
    logic        rdy0, rdy1;
    logic [63:0] out_data;
    logic        out_sof, out_eof, out_vld, out_trunc, out_port, out_rdy;
    logic [2:0]  out_len;
    logic [31:0] frm_cnt_0, frm_cnt_1;
    logic [EW-1:0] stray_cnt, trunc_cnt, sof_err_cnt;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic rdy1_seen;

    logic [70:0] q  [$];
    int          qc [$];

    itch_rx_frame_arbiter #(.MAX_BEATS(MAXB), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst),
        .in_data_0(d[0]), .in_sof_0(sof[0]), .in_eof_0(eof[0]), .in_len_0(len[0]),
        .in_vld_0(vld[0]), .in_rdy_0(rdy0),
        .in_data_1(d[1]), .in_sof_1(sof[1]), .in_eof_1(eof[1]), .in_len_1(len[1]),
        .in_vld_1(vld[1]), .in_rdy_1(rdy1),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .out_len(out_len),
        .out_vld(out_vld), .out_trunc(out_trunc), .out_port(out_port), .out_rdy(out_rdy),
        .frm_cnt_0(frm_cnt_0), .frm_cnt_1(frm_cnt_1),
        .stray_cnt(stray_cnt), .trunc_cnt(trunc_cnt), .sof_err_cnt(sof_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat the downstream actually takes.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            q.push_back({out_trunc, out_port, out_sof, out_eof, out_len, out_data});
            qc.push_back(cyc);
        end
        if (rdy1) rdy1_seen = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [70:0] mk(input logic p, input logic s, input logic e,
                                       input logic [2:0] l, input logic t,
                                       input logic [63:0] dd);
        return {t, p, s, e, l, dd};
    endfunction

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_rdy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; sof[p] = 1'b0; eof[p] = 1'b0; d[p] = '0; len[p] = '0;
        end
        tick(2);
        rst = 1'b0;
        q.delete();
        qc.delete();
    endtask

    task automatic send_frame(input int p, input int n, input logic [63:0] base,
                              input logic [2:0] l, input int mid_sof);
        logic acc;
        int   guard;
        for (int i = 0; i < n; i++) begin
            d[p]   = base + 64'(i);
            sof[p] = (i == 0) || (i == mid_sof);
            eof[p] = (i == n - 1);
            len[p] = l;
            vld[p] = 1'b1;
            acc    = 1'b0;
            guard  = 0;
            while (!acc && guard < 60) begin
                @(negedge clk);
                acc = (p == 1) ? rdy1 : rdy0;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                nvec++; nerr++;
                $display("FAIL send_frame timeout port %0d beat %0d", p, i);
                break;
            end
        end
        vld[p] = 1'b0; sof[p] = 1'b0; eof[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_rdy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; sof[p] = 1'b0; eof[p] = 1'b0; d[p] = '0; len[p] = '0;
        end
        tick(2);
        nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL reset out_vld got %b want 0", out_vld); end
        nvec++; if ({out_sof, out_eof, out_trunc, out_port} !== 4'b0) begin nerr++; $display("FAIL reset flags got %b want 0000", {out_sof, out_eof, out_trunc, out_port}); end
        nvec++; if (out_data !== 64'd0 || out_len !== 3'd0) begin nerr++; $display("FAIL reset data got %h/%0d want 0/0", out_data, out_len); end
        nvec++; if (frm_cnt_0 !== 32'd0 || frm_cnt_1 !== 32'd0) begin nerr++; $display("FAIL reset frm_cnt got %0d/%0d want 0/0", frm_cnt_0, frm_cnt_1); end
        nvec++; if ({stray_cnt, trunc_cnt, sof_err_cnt} !== '0) begin nerr++; $display("FAIL reset err_cnt got %0d/%0d/%0d want 0", stray_cnt, trunc_cnt, sof_err_cnt); end
        rst = 1'b0;
        tick(1);
        nvec++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin nerr++; $display("FAIL reset idle rdy got %b%b want 00", rdy0, rdy1); end
        q.delete();
        qc.delete();
    endtask

    task automatic test_basic();
        logic [70:0] exp [$];
        logic [70:0] got;
        int c0;
        rdy1_seen = 1'b0;
        c0 = cyc;
        send_frame(0, 3, 64'hA000, 3'd5, -1);
        tick(3);
        for (int i = 0; i < 3; i++) exp.push_back(mk(1'b0, i == 0, i == 2, 3'd5, 1'b0, 64'hA000 + 64'(i)));
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            nvec++; if (got !== exp[i]) begin nerr++; $display("FAIL basic beat %0d got %h want %h", i, got, exp[i]); end
            nvec++; if (i >= qc.size() || qc[i] != c0 + 2 + i) begin nerr++; $display("FAIL basic latency beat %0d got cyc %0d want %0d", i, (i < qc.size()) ? qc[i] - c0 : -1, 2 + i); end
        end
        nvec++; if (q.size() != 3) begin nerr++; $display("FAIL basic beat count got %0d want 3", q.size()); end
        nvec++; if (frm_cnt_0 !== 32'd1) begin nerr++; $display("FAIL basic frm_cnt_0 got %0d want 1", frm_cnt_0); end
        nvec++; if (rdy1_seen !== 1'b0) begin nerr++; $display("FAIL basic in_rdy_1 got 1 want 0"); end
    endtask

    task automatic test_alternation();
        logic [70:0] exp [$];
        logic [70:0] got;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            fork
                send_frame(0, 2, 64'hB000 + 64'(r * 256), 3'd1, -1);
                send_frame(1, 2, 64'hC000 + 64'(r * 256), 3'd2, -1);
            join
            for (int i = 0; i < 2; i++) exp.push_back(mk(1'b0, i == 0, i == 1, 3'd1, 1'b0, 64'hB000 + 64'(r * 256 + i)));
            for (int i = 0; i < 2; i++) exp.push_back(mk(1'b1, i == 0, i == 1, 3'd2, 1'b0, 64'hC000 + 64'(r * 256 + i)));
        end
        tick(3);
        for (int i = 0; i < 8; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            nvec++; if (got !== exp[i]) begin nerr++; $display("FAIL alternation beat %0d got %h want %h", i, got, exp[i]); end
        end
        nvec++; if (frm_cnt_0 !== 32'd2 || frm_cnt_1 !== 32'd2) begin nerr++; $display("FAIL alternation frm_cnt got %0d/%0d want 2/2", frm_cnt_0, frm_cnt_1); end
    endtask

    task automatic test_backpressure();
        logic [70:0] exp [$];
        logic [70:0] got;
        int guard;
        do_reset();
        fork
            send_frame(0, 4, 64'hD000, 3'd3, -1);
            begin
                guard = 0;
                while (!out_vld && guard < 20) begin tick(1); guard++; end
                tick(1);
                out_rdy = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick(1);
                    nvec++; if (out_data !== 64'hD001 || out_vld !== 1'b1) begin nerr++; $display("FAIL stall hold %0d got %h/%b want d001/1", k, out_data, out_vld); end
                    nvec++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL stall in_rdy_0 %0d got %b want 0", k, rdy0); end
                end
                out_rdy = 1'b1;
            end
        join
        tick(3);
        for (int i = 0; i < 4; i++) exp.push_back(mk(1'b0, i == 0, i == 3, 3'd3, 1'b0, 64'hD000 + 64'(i)));
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            nvec++; if (got !== exp[i]) begin nerr++; $display("FAIL stall beat %0d got %h want %h", i, got, exp[i]); end
        end
        nvec++; if (q.size() != 4) begin nerr++; $display("FAIL stall beat count got %0d want 4", q.size()); end
        nvec++; if (frm_cnt_0 !== 32'd1 || trunc_cnt !== 2'd0) begin nerr++; $display("FAIL exact-max frame frm/trunc got %0d/%0d want 1/0", frm_cnt_0, trunc_cnt); end
    endtask

    task automatic test_trunc();
        logic [70:0] exp [$];
        logic [70:0] got;
        do_reset();
        send_frame(1, 6, 64'hE000, 3'd7, -1);
        tick(3);
        for (int i = 0; i < 3; i++) exp.push_back(mk(1'b1, i == 0, 1'b0, 3'd7, 1'b0, 64'hE000 + 64'(i)));
        exp.push_back(mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 64'hE003));
        nvec++; if (q.size() != 4) begin nerr++; $display("FAIL trunc beat count got %0d want 4", q.size()); end
        nvec++; if (trunc_cnt !== 2'd1 || frm_cnt_1 !== 32'd0) begin nerr++; $display("FAIL trunc counters got %0d/%0d want 1/0", trunc_cnt, frm_cnt_1); end
        send_frame(1, 1, 64'hF000, 3'd4, -1);
        tick(3);
        exp.push_back(mk(1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 64'hF000));
        for (int i = 0; i < 5; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            nvec++; if (got !== exp[i]) begin nerr++; $display("FAIL trunc beat %0d got %h want %h", i, got, exp[i]); end
        end
        nvec++; if (frm_cnt_1 !== 32'd1) begin nerr++; $display("FAIL single-beat frm_cnt_1 got %0d want 1", frm_cnt_1); end
    endtask

    task automatic test_stray_sof_err();
        logic [70:0] exp [$];
        logic [70:0] got;
        do_reset();
        vld[0] = 1'b1; sof[0] = 1'b0; eof[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[0] = 64'h7700 + 64'(i);
            #1;
            nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL stray in_rdy_0 %0d got %b want 1", i, rdy0); end
            tick(1);
        end
        vld[0] = 1'b0;
        tick(1);
        nvec++; if (stray_cnt !== 2'd3 || q.size() != 0) begin nerr++; $display("FAIL stray count got %0d/%0d beats want 3/0", stray_cnt, q.size()); end
        vld[0] = 1'b1;
        tick(1);
        vld[0] = 1'b0;
        tick(1);
        nvec++; if (stray_cnt !== 2'd3) begin nerr++; $display("FAIL stray saturate got %0d want 3", stray_cnt); end
        send_frame(0, 3, 64'h1000, 3'd6, 1);
        tick(3);
        exp.push_back(mk(1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 64'h1000));
        exp.push_back(mk(1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 64'h1001));
        exp.push_back(mk(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 64'h1002));
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            nvec++; if (got !== exp[i]) begin nerr++; $display("FAIL midsof beat %0d got %h want %h", i, got, exp[i]); end
        end
        nvec++; if (sof_err_cnt !== 2'd1 || frm_cnt_0 !== 32'd1) begin nerr++; $display("FAIL midsof counters got %0d/%0d want 1/1", sof_err_cnt, frm_cnt_0); end
        do_reset();
        vld[0] = 1'b1; vld[1] = 1'b1;
        tick(1);
        vld[0] = 1'b0; vld[1] = 1'b0;
        tick(1);
        nvec++; if (stray_cnt !== 2'd2) begin nerr++; $display("FAIL dual stray got %0d want 2", stray_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [70:0] got;
        do_reset();
        d[0] = 64'h5000; sof[0] = 1'b1; eof[0] = 1'b0; len[0] = 3'd1; vld[0] = 1'b1;
        tick(2);
        d[0] = 64'h5001; sof[0] = 1'b0;
        tick(1);
        d[0] = 64'h5002;
        rst = 1'b1;
        tick(1);
        nvec++; if (out_vld !== 1'b0 || frm_cnt_0 !== 32'd0 || stray_cnt !== 2'd0) begin nerr++; $display("FAIL midreset got vld %b frm %0d stray %0d want 0", out_vld, frm_cnt_0, stray_cnt); end
        rst = 1'b0;
        d[0] = 64'h6000; sof[0] = 1'b1;
        #1;
        nvec++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL midreset idle bubble in_rdy_0 got %b want 0", rdy0); end
        vld[0] = 1'b0; sof[0] = 1'b0;
        q.delete();
        qc.delete();
        send_frame(0, 2, 64'h6000, 3'd2, -1);
        tick(3);
        nvec++; if (q.size() != 2) begin nerr++; $display("FAIL midreset beat count got %0d want 2", q.size()); end
        got = (q.size() > 1) ? q[1] : 'x;
        nvec++; if (got !== mk(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 64'h6001)) begin nerr++; $display("FAIL midreset last beat got %h want eof 6001", got); end
        nvec++; if (frm_cnt_0 !== 32'd1) begin nerr++; $display("FAIL midreset frm_cnt_0 got %0d want 1", frm_cnt_0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternation();
        test_backpressure();
        test_trunc();
        test_stray_sof_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
